// File: rtl/ro_freq_meter.sv
// Gated edge counter for an asynchronous ring-oscillator / delay-line output.
// Counts synchronized RO_i rising edges over a programmable number of CLK_i cycles.
module ro_freq_meter #(
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned GATE_W = 16
) (
   input  logic              CLK_i,
   input  logic              RSTn_i,
   input  logic              RO_i,
   input  logic              START_i,
   input  logic [GATE_W-1:0] GATE_LEN_i,
   input  logic              ACK_i,
   output logic              BUSY_o,
   output logic              VALID_o,
   output logic [CNT_W-1:0]  COUNT_o,
   output logic              OVF_o
);

   typedef enum logic [1:0] {StIdle, StGate, StDone} state_e;

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   state_e              state_q, state_d;
   logic [2:0]          ro_sync_q;
   logic [GATE_W-1:0]   remain_q, remain_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                ovf_q, ovf_d;
   logic                ro_rise;
   logic                start_meas;
   logic                zero_len;

   // [0],[1] form the synchronizer, [2] is the history flop for edge detection
   assign ro_rise    = ro_sync_q[1] & ~ro_sync_q[2];
   assign zero_len   = (GATE_LEN_i == '0);
   assign start_meas = START_i & ((state_q == StIdle) | ((state_q == StDone) & ACK_i));

   always_ff @(posedge CLK_i or negedge RSTn_i) begin
      if (!RSTn_i) begin
         ro_sync_q <= '0;
      end else begin
         ro_sync_q <= {ro_sync_q[1:0], RO_i};
      end
   end

   always_ff @(posedge CLK_i or negedge RSTn_i) begin
      if (!RSTn_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start_meas) state_d = zero_len ? StDone : StGate;
         end
         StGate: begin
            if (remain_q <= GATE_W'(1)) state_d = StDone;
         end
         StDone: begin
            if (ACK_i) begin
               if (start_meas) state_d = zero_len ? StDone : StGate;
               else            state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      remain_d = remain_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (start_meas) begin
         remain_d = GATE_LEN_i;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else if (state_q == StGate) begin
         remain_d = remain_q - GATE_W'(1);
         if (ro_rise) begin
            if (count_q == CntMax) ovf_d = 1'b1;
            else                   count_d = count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLK_i or negedge RSTn_i) begin
      if (!RSTn_i) begin
         remain_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         remain_q <= remain_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      BUSY_o  = (state_q == StGate);
      VALID_o = (state_q == StDone);
      COUNT_o = count_q;
      OVF_o   = ovf_q;
   end

endmodule
